// File: rtl/simmem_pkg.sv
// Shared types and default sizing for the simmem traffic gate.
package simmem_pkg;

    typedef enum logic [1:0] {
        GateDisabled,
        GateEnabled,
        GateDraining
    } gate_state_e;

    localparam int unsigned DefNumChans = 2;
    localparam int unsigned DefMaxOutst = 32;
    localparam int unsigned DefOutstW   = 6;

endpackage

// File: rtl/simmem_outst_counter.sv
// Per-channel outstanding-transaction counter.
// Its underflow output is a pulse; the caller makes it sticky.
module simmem_outst_counter #(
    parameter int unsigned MaxOutst = 32,
    parameter int unsigned OutstW   = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [OutstW-1:0] cnt_o,
    output logic              at_max_o,
    output logic              is_zero_o,
    output logic              underflow_o
);

    logic [OutstW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + OutstW'(1);
        end else if (!inc_i && dec_i) begin
            // A retirement with nothing outstanding holds the count at zero.
            if (cnt_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_d = cnt_q - OutstW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign at_max_o  = (cnt_q >= OutstW'(MaxOutst));
    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/simmem_traffic_gate.sv
// Enable/drain gate on the simmem address channels; disabling waits until
// every channel has retired its outstanding transactions.
module simmem_traffic_gate
    import simmem_pkg::*;
#(
    parameter int unsigned NumChans = DefNumChans,
    parameter int unsigned MaxOutst = DefMaxOutst,
    parameter int unsigned OutstW   = DefOutstW
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_req_i,
    input  logic [NumChans-1:0]        addr_in_valid_i,
    output logic [NumChans-1:0]        addr_in_ready_o,
    output logic [NumChans-1:0]        addr_out_valid_o,
    input  logic [NumChans-1:0]        addr_out_ready_i,
    input  logic [NumChans-1:0]        rsp_done_i,
    output logic [NumChans*OutstW-1:0] outst_cnt_o,
    output logic                       en_o,
    output logic                       idle_o,
    output logic                       underflow_o
);

    gate_state_e state_q, state_d;

    logic [NumChans-1:0] at_max;
    logic [NumChans-1:0] is_zero;
    logic [NumChans-1:0] uf_pulse;
    logic [NumChans-1:0] gate_open;
    logic [NumChans-1:0] acc;
    logic                underflow_q, underflow_d;

    assign gate_open        = (state_q == GateEnabled) ? ~at_max : '0;
    assign addr_out_valid_o = addr_in_valid_i & gate_open;
    assign addr_in_ready_o  = addr_out_ready_i & gate_open;
    assign acc              = addr_in_valid_i & addr_out_ready_i & gate_open;

    for (genvar c = 0; c < NumChans; c++) begin : g_chan
        simmem_outst_counter #(
            .MaxOutst (MaxOutst),
            .OutstW   (OutstW)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .inc_i       (acc[c]),
            .dec_i       (rsp_done_i[c]),
            .cnt_o       (outst_cnt_o[c*OutstW +: OutstW]),
            .at_max_o    (at_max[c]),
            .is_zero_o   (is_zero[c]),
            .underflow_o (uf_pulse[c])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GateDisabled: if (en_req_i) state_d = GateEnabled;
            GateEnabled:  if (!en_req_i) state_d = GateDraining;
            // Re-enable wins over drain completion.
            GateDraining: begin
                if (en_req_i) begin
                    state_d = GateEnabled;
                end else if (&is_zero) begin
                    state_d = GateDisabled;
                end
            end
            default:      state_d = GateDisabled;
        endcase
    end

    assign underflow_d = underflow_q | (|uf_pulse);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= GateDisabled;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            underflow_q <= underflow_d;
        end
    end

    assign en_o        = (state_q == GateEnabled);
    assign idle_o      = (state_q == GateDisabled);
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_simmem_traffic_gate.sv
// Directed bench: stimulus queues cycle-tagged expectations, a negedge
// monitor pops and compares them against the gate outputs.
module tb_simmem_traffic_gate;

    localparam int unsigned NumChans = 2;
    localparam int unsigned MaxOutst = 4;
    localparam int unsigned OutstW   = 6;

    logic                       clk;
    logic                       rst;
    logic                       en_req;
    logic [NumChans-1:0]        in_valid;
    logic [NumChans-1:0]        in_ready;
    logic [NumChans-1:0]        out_valid;
    logic [NumChans-1:0]        out_ready;
    logic [NumChans-1:0]        done;
    logic [NumChans*OutstW-1:0] cnt;
    logic                       en;
    logic                       idle;
    logic                       uf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          tag;
        logic        en;
        logic        idle;
        logic        uf;
        logic [5:0]  c0;
        logic [5:0]  c1;
        logic [1:0]  rdy;
        logic [1:0]  vld;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    simmem_traffic_gate #(
        .NumChans (NumChans),
        .MaxOutst (MaxOutst),
        .OutstW   (OutstW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .en_req_i         (en_req),
        .addr_in_valid_i  (in_valid),
        .addr_in_ready_o  (in_ready),
        .addr_out_valid_o (out_valid),
        .addr_out_ready_i (out_ready),
        .rsp_done_i       (done),
        .outst_cnt_o      (cnt),
        .en_o             (en),
        .idle_o           (idle),
        .underflow_o      (uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, tag, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].tag <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.tag != cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_record: tag %0d seen at cycle %0d", mon_e.tag, cyc);
            end else begin
                cmp("en_o",        mon_e.tag, 32'(en),        32'(mon_e.en));
                cmp("idle_o",      mon_e.tag, 32'(idle),      32'(mon_e.idle));
                cmp("underflow_o", mon_e.tag, 32'(uf),        32'(mon_e.uf));
                cmp("cnt0",        mon_e.tag, 32'(cnt[5:0]),  32'(mon_e.c0));
                cmp("cnt1",        mon_e.tag, 32'(cnt[11:6]), 32'(mon_e.c1));
                cmp("in_ready",    mon_e.tag, 32'(in_ready),  32'(mon_e.rdy));
                cmp("out_valid",   mon_e.tag, 32'(out_valid), 32'(mon_e.vld));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] iv, input logic [1:0] orr,
                         input logic [1:0] d);
        en_req    = e;
        in_valid  = iv;
        out_ready = orr;
        done      = d;
    endtask

    task automatic expect_now(input logic e, input logic i, input logic u, input int c0,
                              input int c1, input logic [1:0] r, input logic [1:0] v);
        exp_t x;
        x.tag  = cyc;
        x.en   = e;
        x.idle = i;
        x.uf   = u;
        x.c0   = 6'(c0);
        x.c1   = 6'(c1);
        x.rdy  = r;
        x.vld  = v;
        q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 2'b00);
        tick(); tick();
        rst = 1'b0;
        // Disabled: traffic is presented but nothing passes.
        drive(1'b0, 2'b11, 2'b11, 2'b00); expect_now(0, 1, 0, 0, 0, 2'b00, 2'b00); tick();
        expect_now(0, 1, 0, 0, 0, 2'b00, 2'b00); tick();
        drive(1'b1, 2'b11, 2'b11, 2'b00); expect_now(0, 1, 0, 0, 0, 2'b00, 2'b00); tick();
        drive(1'b1, 2'b00, 2'b01, 2'b00); expect_now(1, 0, 0, 0, 0, 2'b01, 2'b00); tick();
        drive(1'b1, 2'b00, 2'b10, 2'b00); expect_now(1, 0, 0, 0, 0, 2'b10, 2'b00); tick();
        // Fill chan0 up to the cap of 4.
        drive(1'b1, 2'b01, 2'b11, 2'b00); expect_now(1, 0, 0, 0, 0, 2'b11, 2'b01); tick();
        expect_now(1, 0, 0, 1, 0, 2'b11, 2'b01); tick();
        expect_now(1, 0, 0, 2, 0, 2'b11, 2'b01); tick();
        expect_now(1, 0, 0, 3, 0, 2'b11, 2'b01); tick();
        drive(1'b1, 2'b11, 2'b11, 2'b00); expect_now(1, 0, 0, 4, 0, 2'b10, 2'b10); tick();
        drive(1'b1, 2'b01, 2'b11, 2'b01); expect_now(1, 0, 0, 4, 1, 2'b10, 2'b00); tick();
        drive(1'b1, 2'b00, 2'b11, 2'b00); expect_now(1, 0, 0, 3, 1, 2'b11, 2'b00); tick();
        // Chan1: accept plus retire in the same cycle at count 2.
        drive(1'b1, 2'b10, 2'b11, 2'b00); expect_now(1, 0, 0, 3, 1, 2'b11, 2'b10); tick();
        drive(1'b1, 2'b10, 2'b11, 2'b10); expect_now(1, 0, 0, 3, 2, 2'b11, 2'b10); tick();
        drive(1'b1, 2'b00, 2'b11, 2'b10); expect_now(1, 0, 0, 3, 2, 2'b11, 2'b00); tick();
        expect_now(1, 0, 0, 3, 1, 2'b11, 2'b00); tick();
        // Drain with 3 outstanding on chan0.
        drive(1'b0, 2'b00, 2'b11, 2'b00); expect_now(1, 0, 0, 3, 0, 2'b11, 2'b00); tick();
        drive(1'b0, 2'b11, 2'b11, 2'b01); expect_now(0, 0, 0, 3, 0, 2'b00, 2'b00); tick();
        expect_now(0, 0, 0, 2, 0, 2'b00, 2'b00); tick();
        // Re-enable from Draining with one outstanding.
        drive(1'b1, 2'b00, 2'b11, 2'b00); expect_now(0, 0, 0, 1, 0, 2'b00, 2'b00); tick();
        drive(1'b0, 2'b00, 2'b11, 2'b00); expect_now(1, 0, 0, 1, 0, 2'b11, 2'b00); tick();
        drive(1'b0, 2'b00, 2'b11, 2'b01); expect_now(0, 0, 0, 1, 0, 2'b00, 2'b00); tick();
        drive(1'b0, 2'b00, 2'b11, 2'b00); expect_now(0, 0, 0, 0, 0, 2'b00, 2'b00); tick();
        // Idle one cycle after the count reached zero; then force an underflow.
        drive(1'b0, 2'b00, 2'b11, 2'b01); expect_now(0, 1, 0, 0, 0, 2'b00, 2'b00); tick();
        drive(1'b0, 2'b00, 2'b11, 2'b00); expect_now(0, 1, 1, 0, 0, 2'b00, 2'b00); tick();
        rst = 1'b1; expect_now(0, 1, 1, 0, 0, 2'b00, 2'b00); tick();
        rst = 1'b0;
        // Enabled with nothing outstanding still passes through Draining.
        drive(1'b1, 2'b00, 2'b11, 2'b00); expect_now(0, 1, 0, 0, 0, 2'b00, 2'b00); tick();
        drive(1'b0, 2'b00, 2'b11, 2'b00); expect_now(1, 0, 0, 0, 0, 2'b11, 2'b00); tick();
        expect_now(0, 0, 0, 0, 0, 2'b00, 2'b00); tick();
        expect_now(0, 1, 0, 0, 0, 2'b00, 2'b00); tick();
        tick(); tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_records: got %0d, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
